// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pkg
//  Purpose  : Shared types for the branch tracker. It holds the in-flight
//             branch record and the tracker state encoding.
//  Contents : MaxWordSize - widest address the entry record can carry
//             br_entry_t  - {taken, pc, addr}
//             br_state_t  - IDLE / TRACK / RECOVER
//  Revision : 1.0 - initial release
// ============================================================================
package branch_pkg;

  // A package type cannot follow a module parameter. Entries are therefore
  // sized for the widest supported word, and narrower instances zero-extend
  // their addresses into them. WordSize must not exceed this value.
  localparam int MaxWordSize = 64;

  typedef struct packed {
    logic                   taken;
    logic [MaxWordSize-1:0] pc;
    logic [MaxWordSize-1:0] addr;
  } br_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    RECOVER = 2'd2
  } br_state_t;

endpackage
`default_nettype wire

// File: rtl/br_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : br_fifo
//  Purpose  : Circular buffer of in-flight branch entries, with head/tail
//             pointers, push/pop and a synchronous clear.
//  Ports    : clk, rstn          - clock, async active-low reset
//             clear              - drop all entries (sync)
//             push / wdata       - append an entry at the tail
//             pop                - retire the head entry
//             head_entry         - oldest entry (undefined when empty)
//             count, full, empty - registered occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module br_fifo
  import branch_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  br_entry_t                wdata,
  output br_entry_t                head_entry,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  br_entry_t       mem [Depth];
  logic [PtrW-1:0] head;
  logic [PtrW-1:0] tail;
  logic [CntW-1:0] count_next;

  always_comb begin
    count_next = count + CntW'(push) - CntW'(pop);
  end

  // Because Depth is a power of two, the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) tail <= tail + PtrW'(1);
      if (pop)  head <= head + PtrW'(1);
      count <= count_next;
      full  <= (count_next == CntW'(Depth));
      empty <= (count_next == '0);
    end
  end

  // Storage needs no reset. When a push and a pop happen together on a full
  // buffer, tail equals head. The slot is written as it is vacated, and the
  // pop has already consumed the old value this cycle.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail] <= wdata;
  end

  assign head_entry = mem[head];

endmodule
`default_nettype wire

// File: rtl/branch_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : branch_tracker
//  Purpose  : Tracks predicted branches in order, resolves the oldest one and
//             on a mispredict issues a one-cycle redirect with the corrected
//             fetch address, then squashes the pipeline for RecoverCycles.
//  Ports    : clk, rstn                  - clock, async active-low reset
//             push, push_taken,
//             push_pc, push_addr         - new predicted branch from fetch
//             resolve, act_taken         - outcome of the oldest branch
//             full, empty, count         - occupancy (registered)
//             redirect, npc              - mispredict pulse and new fetch PC
//             flush                      - pipeline squash in progress
//  Revision : 1.0 - initial release
// ============================================================================
module branch_tracker
  import branch_pkg::*;
#(
  parameter int WordSize      = 32,
  parameter int Depth         = 4,
  parameter int RecoverCycles = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   push_taken,
  input  logic [WordSize-1:0]    push_pc,
  input  logic [WordSize-1:0]    push_addr,
  input  logic                   resolve,
  input  logic                   act_taken,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count,
  output logic                   redirect,
  output logic [WordSize-1:0]    npc,
  output logic                   flush
);

  localparam int CntW = $clog2(Depth) + 1;
  localparam int RcW  = (RecoverCycles > 1) ? $clog2(RecoverCycles) : 1;

  br_state_t       state;
  logic [RcW-1:0]  rec_cnt;
  br_entry_t       head;
  br_entry_t       wdata;
  logic            res_valid;
  logic            mispredict;
  logic            pop;
  logic            push_ok;
  logic [CntW-1:0] count_next;
  logic            unused_hi;

  always_comb begin
    wdata      = '{taken: push_taken,
                   pc:    MaxWordSize'(push_pc),
                   addr:  MaxWordSize'(push_addr)};
    res_valid  = resolve && !empty && (state != RECOVER);
    mispredict = res_valid && (act_taken != head.taken);
    pop        = res_valid && !mispredict;
    // A full buffer still accepts a push when the head retires in the same cycle.
    push_ok    = push && (state != RECOVER) && !mispredict && (!full || pop);
    count_next = count + CntW'(push_ok) - CntW'(pop);
  end

  // Address bits above WordSize are always zero. This reduction only marks
  // them as consumed.
  assign unused_hi = ^(head.pc >> WordSize) ^ ^(head.addr >> WordSize);

  br_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (mispredict),
    .push       (push_ok),
    .pop        (pop),
    .wdata      (wdata),
    .head_entry (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rec_cnt  <= '0;
      redirect <= 1'b0;
      flush    <= 1'b0;
      npc      <= '0;
    end else begin
      redirect <= 1'b0;
      case (state)
        IDLE, TRACK: begin
          if (mispredict) begin
            state    <= RECOVER;
            redirect <= 1'b1;
            flush    <= 1'b1;
            rec_cnt  <= RcW'(RecoverCycles - 1);
            npc      <= act_taken ? head.addr[WordSize-1:0]
                                  : head.pc[WordSize-1:0] + WordSize'(4);
          end else begin
            state <= (count_next == '0) ? IDLE : TRACK;
          end
        end
        RECOVER: begin
          // rec_cnt holds the flush cycles remaining after the current one.
          if (rec_cnt == '0) begin
            flush <= 1'b0;
            state <= IDLE;
          end else begin
            rec_cnt <= rec_cnt - RcW'(1);
          end
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_tracker
//  Purpose  : Self-checking bench for branch_tracker (WordSize=32, Depth=4,
//             RecoverCycles=2), using directed vectors with hand-computed
//             expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_tracker;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        push = 1'b0;
  logic        push_taken = 1'b0;
  logic [31:0] push_pc = '0;
  logic [31:0] push_addr = '0;
  logic        resolve = 1'b0;
  logic        act_taken = 1'b0;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        redirect;
  logic [31:0] npc;
  logic        flush;

  int checks = 0;
  int failures = 0;

  branch_tracker #(
    .WordSize      (32),
    .Depth         (4),
    .RecoverCycles (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push),
    .push_taken (push_taken),
    .push_pc    (push_pc),
    .push_addr  (push_addr),
    .resolve    (resolve),
    .act_taken  (act_taken),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .redirect   (redirect),
    .npc        (npc),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        resolve;
    logic        act;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        redirect;
    logic        flush;
    logic [31:0] npc;
  } vec_t;

  function automatic vec_t mk(logic p, logic t, logic [31:0] pc, logic [31:0] a,
                              logic r, logic act, logic [2:0] c, logic f, logic e,
                              logic rd, logic fl, logic [31:0] n);
    vec_t v;
    v.push = p; v.taken = t; v.pc = pc; v.addr = a; v.resolve = r; v.act = act;
    v.count = c; v.full = f; v.empty = e; v.redirect = rd; v.flush = fl; v.npc = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " count"},    32'(count),    32'(v.count));
    check({tag, " full"},     32'(full),     32'(v.full));
    check({tag, " empty"},    32'(empty),    32'(v.empty));
    check({tag, " redirect"}, 32'(redirect), 32'(v.redirect));
    check({tag, " flush"},    32'(flush),    32'(v.flush));
    check({tag, " npc"},      npc,           v.npc);
  endtask

  // Drive the inputs away from the edge, clock once, then sample 1 time
  // unit after the edge.
  task automatic step(input vec_t v);
    push = v.push; push_taken = v.taken; push_pc = v.pc; push_addr = v.addr;
    resolve = v.resolve; act_taken = v.act;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [28];

  initial begin
    //              push tk pc            addr      res act cnt f e rd fl npc
    vecs[0]  = mk(1, 1, 32'h100,      32'h200, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,        32'h0,   1, 1, 0, 0, 1, 0, 0, 32'h0);
    vecs[2]  = mk(1, 1, 32'h100,      32'h200, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    vecs[3]  = mk(0, 0, 32'h0,        32'h0,   1, 0, 0, 0, 1, 1, 1, 32'h104);
    vecs[4]  = mk(0, 0, 32'h0,        32'h0,   0, 0, 0, 0, 1, 0, 1, 32'h104);
    vecs[5]  = mk(0, 0, 32'h0,        32'h0,   0, 0, 0, 0, 1, 0, 0, 32'h104);
    vecs[6]  = mk(1, 1, 32'h10,       32'h20,  0, 0, 1, 0, 0, 0, 0, 32'h104);
    vecs[7]  = mk(1, 0, 32'h30,       32'h40,  0, 0, 2, 0, 0, 0, 0, 32'h104);
    vecs[8]  = mk(1, 1, 32'h50,       32'h60,  0, 0, 3, 0, 0, 0, 0, 32'h104);
    vecs[9]  = mk(1, 0, 32'h70,       32'h80,  0, 0, 4, 1, 0, 0, 0, 32'h104);
    vecs[10] = mk(1, 1, 32'h90,       32'h94,  0, 0, 4, 1, 0, 0, 0, 32'h104);
    vecs[11] = mk(1, 0, 32'hA0,       32'hB0,  1, 1, 4, 1, 0, 0, 0, 32'h104);
    vecs[12] = mk(0, 0, 32'h0,        32'h0,   1, 0, 3, 0, 0, 0, 0, 32'h104);
    vecs[13] = mk(0, 0, 32'h0,        32'h0,   1, 1, 2, 0, 0, 0, 0, 32'h104);
    vecs[14] = mk(0, 0, 32'h0,        32'h0,   1, 0, 1, 0, 0, 0, 0, 32'h104);
    vecs[15] = mk(0, 0, 32'h0,        32'h0,   1, 0, 0, 0, 1, 0, 0, 32'h104);
    vecs[16] = mk(0, 0, 32'h0,        32'h0,   1, 1, 0, 0, 1, 0, 0, 32'h104);
    vecs[17] = mk(1, 1, 32'hFFFFFFFC, 32'h10,  0, 0, 1, 0, 0, 0, 0, 32'h104);
    vecs[18] = mk(0, 0, 32'h0,        32'h0,   1, 0, 0, 0, 1, 1, 1, 32'h0);
    vecs[19] = mk(1, 1, 32'h11,       32'h22,  0, 0, 0, 0, 1, 0, 1, 32'h0);
    vecs[20] = mk(1, 1, 32'h11,       32'h22,  0, 0, 0, 0, 1, 0, 0, 32'h0);
    vecs[21] = mk(1, 0, 32'h300,      32'h400, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    vecs[22] = mk(1, 1, 32'h500,      32'h600, 0, 0, 2, 0, 0, 0, 0, 32'h0);
    vecs[23] = mk(1, 1, 32'h111,      32'h222, 1, 1, 0, 0, 1, 1, 1, 32'h400);
    vecs[24] = mk(1, 1, 32'h111,      32'h222, 1, 1, 0, 0, 1, 0, 1, 32'h400);
    vecs[25] = mk(1, 1, 32'h111,      32'h222, 0, 0, 0, 0, 1, 0, 0, 32'h400);
    vecs[26] = mk(1, 1, 32'h700,      32'h800, 0, 0, 1, 0, 0, 0, 0, 32'h400);
    vecs[27] = mk(0, 0, 32'h0,        32'h0,   1, 1, 0, 0, 1, 0, 0, 32'h400);

    // Reset state
    #2 rstn = 1'b0;
    #20;
    check_all("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0));
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 28; i++) begin
      step(vecs[i]);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset asserted during the first flush cycle
    step(mk(1, 1, 32'h900, 32'hA00, 0, 0, 0, 0, 0, 0, 0, 0));
    check("mid push count", 32'(count), 32'd1);
    step(mk(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0));
    check("mid redirect", 32'(redirect), 32'd1);
    check("mid flush", 32'(flush), 32'd1);
    check("mid npc", npc, 32'h904);
    #2 rstn = 1'b0;
    #1;
    check_all("async reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0));
    @(negedge clk);
    rstn = 1'b1;
    // Recovery is abandoned, so the tracker is back in IDLE and accepts a push.
    step(mk(1, 0, 32'h40, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0));
    check_all("post reset push", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
